flag_access_controller: RTL and testbench
=========================================

Name: flag_access_controller

Overview:
Initiator/writer side of the per-slot valid-flag store in the hashtable datapath. It accepts lookup/insert/delete requests carrying two candidate slot addresses from the hash units. It drives the flag store's two read addresses and consumes its 1-cycle-latency flag outputs. It then decides and issues the single flag write, returns a response, and tracks occupancy and insert-failure statistics.

Parameters:
SIZE, 10, slot address width; table holds 2**SIZE slots
CNT_W, 16, width of saturating insert-failure counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request (IDLE only)
req_op  in  2  00 lookup, 01 insert, 10 delete, 11 reserved
req_adr_0  in  SIZE  candidate slot from hash 0
req_adr_1  in  SIZE  candidate slot from hash 1
resp_valid  out  1  response present, held until resp_ready
resp_ready  in  1  consumer accepts response
resp_ok  out  1  operation succeeded / lookup hit
resp_slot  out  SIZE  slot chosen, hit, or cleared
resp_which  out  1  0 = candidate 0, 1 = candidate 1
read_adr_0  out  SIZE  flag store read address 0
read_adr_1  out  SIZE  flag store read address 1
flag_in_0  in  1  flag store output 0, valid one cycle after address
flag_in_1  in  1  flag store output 1
write_adr  out  SIZE  flag store write address
write_en  out  1  flag store write strobe
write_is_valid  out  1  flag value to write
occupancy  out  SIZE+1  number of valid slots
fail_count  out  CNT_W  failed inserts, saturating

Behaviour:
- Reset (clk, reset synchronous active-high) values: state IDLE, req_ready 1, resp_valid 0, resp_ok 0, resp_slot 0, resp_which 0, write_en 0, write_adr 0, write_is_valid 0, read_adr_* 0, occupancy 0, fail_count 0. The flag store is reset by the same signal.
- FSM states: IDLE -> READ -> WAIT -> RESP -> IDLE. Only one transaction is in flight at a time, so read-after-write hazards are impossible.
- IDLE: req_ready=1. On req_valid, latch op and addresses into registers, then go to READ. read_adr_0/1 are driven from the latched registers.
- READ: addresses are stable at the flag store, which samples them at this edge. Go to WAIT.
- WAIT: flag_in_0/1 are valid. Compute the result, register it, and go to RESP.
  - Lookup: ok = f0|f1; which = f0 ? 0 : 1; slot = matching address (adr_1 on a miss). No write.
  - Insert: if !f0, use adr_0 (which 0); else if !f1, use adr_1 (which 1); else ok=0, slot=adr_0, no write, fail_count += 1 (saturating at all-ones). On success: write_is_valid=1, occupancy += 1.
  - Delete: always targets adr_0. Write 0 to adr_0. ok = f0; slot=adr_0; which 0. occupancy -= 1 only if f0 was 1.
  - Reserved op: ok=0, no write, counters unchanged; slot=adr_0, which 0.
  - Insert with adr_0==adr_1 and f0=1 is a fail; the same slot is not re-checked as a free slot.
- write_en is a single-cycle pulse in the first RESP cycle. The response fields become valid together with it.
- RESP: resp_valid=1 and fields are held stable until resp_ready. The exit occurs on the edge where resp_ready=1. Earliest next accept is the following IDLE cycle.
- Latency: request accepted at edge N; write_en and resp_valid are high in cycle N+3. Minimum request-to-request interval is 4 cycles.
- Occupancy never exceeds 2**SIZE and never goes below 0. Both updates saturate defensively.
- Reset mid-transaction aborts to IDLE. No write is issued, no response is produced, and counters are cleared.

Test Plan:
- Reset, then insert adr_0=5, adr_1=9 -> write_en one cycle, write_adr=5, write_is_valid=1, resp_ok=1, which=0, occupancy=1, 3-cycle latency.
- Insert adr_0=5, adr_1=9 again -> slot 9, which=1, occupancy=2. Third insert (5,9) -> resp_ok=0, no write_en, fail_count=1.
- Lookup (7,9) -> resp_ok=1, slot=9, which=1. Lookup (7,8) -> resp_ok=0, no write.
- Delete adr_0=5 -> write_adr=5, write_is_valid=0, ok=1, occupancy=1. Repeat delete of 5 -> ok=0, occupancy unchanged.
- Hold resp_ready=0 for 5 cycles -> resp fields stable, write_en high only one cycle, req_ready=0 throughout.
- Assert reset in the WAIT state of an insert -> no write_en, no resp_valid, occupancy=0. Subsequent lookup of that slot -> resp_ok=0.

Source files
------------

// File: rtl/flag_access_controller.sv
// -----------------------------------------------------------------------------
// flag_access_controller
//
// Writer side of the per-slot valid-flag store. One lookup/insert/delete
// request is handled at a time:
//   IDLE -> READ (flag store samples read addresses)
//        -> WAIT (flags valid, result computed)
//        -> RESP (write pulse on first cycle, response held until accepted)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_op              00 lookup, 01 insert, 10 delete, 11 reserved
//   req_adr_0/1         candidate slots from the two hash units
//   resp_valid/ready    response handshake
//   resp_ok             success / lookup hit
//   resp_slot           slot chosen, hit or cleared
//   resp_which          candidate index of resp_slot
//   read_adr_0/1        flag store read addresses
//   flag_in_0/1         flag store outputs (one cycle read latency)
//   write_adr/en/is_valid  flag store write port
//   occupancy           number of valid slots
//   fail_count          saturating count of failed inserts
// -----------------------------------------------------------------------------
module flag_access_controller #(
  parameter int SIZE  = 10,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [SIZE-1:0]   req_adr_0,
  input  logic [SIZE-1:0]   req_adr_1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_ok,
  output logic [SIZE-1:0]   resp_slot,
  output logic              resp_which,
  output logic [SIZE-1:0]   read_adr_0,
  output logic [SIZE-1:0]   read_adr_1,
  input  logic              flag_in_0,
  input  logic              flag_in_1,
  output logic [SIZE-1:0]   write_adr,
  output logic              write_en,
  output logic              write_is_valid,
  output logic [SIZE:0]     occupancy,
  output logic [CNT_W-1:0]  fail_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  localparam logic [1:0]       OP_LOOKUP = 2'b00;
  localparam logic [1:0]       OP_INSERT = 2'b01;
  localparam logic [1:0]       OP_DELETE = 2'b10;
  localparam logic [SIZE:0]    OCC_MAX   = {1'b1, {SIZE{1'b0}}};
  localparam logic [SIZE:0]    OCC_ZERO  = {(SIZE+1){1'b0}};
  localparam logic [SIZE:0]    OCC_ONE   = {{SIZE{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0]  ADR_ZERO  = {SIZE{1'b0}};

  state_t            state_r, state_s;
  logic              capture_s;
  logic [1:0]        op_r;
  logic [SIZE-1:0]   adr0_r, adr1_r;

  logic              req_ready_r, req_ready_s;
  logic              resp_valid_r, resp_valid_s;
  logic              resp_ok_r, resp_ok_s;
  logic [SIZE-1:0]   resp_slot_r, resp_slot_s;
  logic              resp_which_r, resp_which_s;
  logic [SIZE-1:0]   write_adr_r, write_adr_s;
  logic              write_en_r, write_en_s;
  logic              write_is_valid_r, write_is_valid_s;
  logic [SIZE:0]     occupancy_r, occupancy_s;
  logic [CNT_W-1:0]  fail_count_r, fail_count_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch; read addresses come straight from here
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r   <= 2'b00;
      adr0_r <= ADR_ZERO;
      adr1_r <= ADR_ZERO;
    end else if (capture_s) begin
      op_r   <= req_op;
      adr0_r <= req_adr_0;
      adr1_r <= req_adr_1;
    end else begin
      op_r   <= op_r;
      adr0_r <= adr0_r;
      adr1_r <= adr1_r;
    end
  end

  // Next-state and next-output decision
  always_comb begin
    state_s          = state_r;
    capture_s        = 1'b0;
    req_ready_s      = req_ready_r;
    resp_valid_s     = resp_valid_r;
    resp_ok_s        = resp_ok_r;
    resp_slot_s      = resp_slot_r;
    resp_which_s     = resp_which_r;
    write_adr_s      = write_adr_r;
    write_en_s       = 1'b0;          // write is a one-cycle pulse
    write_is_valid_s = write_is_valid_r;
    occupancy_s      = occupancy_r;
    fail_count_s     = fail_count_r;

    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s     = ST_READ;
          capture_s   = 1'b1;
          req_ready_s = 1'b0;
        end else begin
          state_s     = ST_IDLE;
        end
      end

      ST_READ: begin
        state_s = ST_WAIT;
      end

      ST_WAIT: begin
        state_s      = ST_RESP;
        resp_valid_s = 1'b1;
        resp_ok_s    = 1'b0;
        resp_slot_s  = adr0_r;
        resp_which_s = 1'b0;
        case (op_r)
          OP_LOOKUP: begin
            resp_ok_s    = flag_in_0 | flag_in_1;
            resp_which_s = ~flag_in_0;
            resp_slot_s  = flag_in_0 ? adr0_r : adr1_r;
          end
          OP_INSERT: begin
            // Candidate 1 is only considered when candidate 0 is taken, so
            // adr_0 == adr_1 with the slot taken falls through to a failure.
            if (!flag_in_0) begin
              resp_ok_s        = 1'b1;
              write_en_s       = 1'b1;
              write_adr_s      = adr0_r;
              write_is_valid_s = 1'b1;
              occupancy_s      = (occupancy_r != OCC_MAX) ? occupancy_r + OCC_ONE : occupancy_r;
            end else if (!flag_in_1) begin
              resp_ok_s        = 1'b1;
              resp_slot_s      = adr1_r;
              resp_which_s     = 1'b1;
              write_en_s       = 1'b1;
              write_adr_s      = adr1_r;
              write_is_valid_s = 1'b1;
              occupancy_s      = (occupancy_r != OCC_MAX) ? occupancy_r + OCC_ONE : occupancy_r;
            end else begin
              fail_count_s     = (fail_count_r != CNT_MAX) ? fail_count_r + CNT_ONE : fail_count_r;
            end
          end
          OP_DELETE: begin
            resp_ok_s        = flag_in_0;
            write_en_s       = 1'b1;
            write_adr_s      = adr0_r;
            write_is_valid_s = 1'b0;
            if (flag_in_0 && (occupancy_r != OCC_ZERO)) begin
              occupancy_s = occupancy_r - OCC_ONE;
            end else begin
              occupancy_s = occupancy_r;
            end
          end
          default: begin
            resp_ok_s = 1'b0;  // reserved op: no write, counters untouched
          end
        endcase
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_s      = ST_IDLE;
          resp_valid_s = 1'b0;
          req_ready_s  = 1'b1;
        end else begin
          state_s      = ST_RESP;
        end
      end

      default: begin
        state_s      = ST_IDLE;
        resp_valid_s = 1'b0;
        req_ready_s  = 1'b1;
      end
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready_r      <= 1'b1;
      resp_valid_r     <= 1'b0;
      resp_ok_r        <= 1'b0;
      resp_slot_r      <= ADR_ZERO;
      resp_which_r     <= 1'b0;
      write_adr_r      <= ADR_ZERO;
      write_en_r       <= 1'b0;
      write_is_valid_r <= 1'b0;
      occupancy_r      <= OCC_ZERO;
      fail_count_r     <= {CNT_W{1'b0}};
    end else begin
      req_ready_r      <= req_ready_s;
      resp_valid_r     <= resp_valid_s;
      resp_ok_r        <= resp_ok_s;
      resp_slot_r      <= resp_slot_s;
      resp_which_r     <= resp_which_s;
      write_adr_r      <= write_adr_s;
      write_en_r       <= write_en_s;
      write_is_valid_r <= write_is_valid_s;
      occupancy_r      <= occupancy_s;
      fail_count_r     <= fail_count_s;
    end
  end

  assign req_ready      = req_ready_r;
  assign resp_valid     = resp_valid_r;
  assign resp_ok        = resp_ok_r;
  assign resp_slot      = resp_slot_r;
  assign resp_which     = resp_which_r;
  assign read_adr_0     = adr0_r;
  assign read_adr_1     = adr1_r;
  assign write_adr      = write_adr_r;
  assign write_en       = write_en_r;
  assign write_is_valid = write_is_valid_r;
  assign occupancy      = occupancy_r;
  assign fail_count     = fail_count_r;

endmodule

// File: tb/tb_flag_access_controller.sv
// -----------------------------------------------------------------------------
// tb_flag_access_controller
//
// Directed bench. A flag store with one-cycle read latency sits beside the
// DUT. A transaction-level model (a set of occupied slots plus two counters)
// predicts each response. A compare process checks the DUT against the
// expectations every falling edge. Each request also carries hand-computed
// expected results that pin the model.
// -----------------------------------------------------------------------------
module tb_flag_access_controller;

  localparam int SIZE  = 10;
  localparam int CNT_W = 16;
  localparam int NSLOT = 1 << SIZE;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'b00;
  logic [SIZE-1:0]   req_adr_0 = '0;
  logic [SIZE-1:0]   req_adr_1 = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic              resp_ok;
  logic [SIZE-1:0]   resp_slot;
  logic              resp_which;
  logic [SIZE-1:0]   read_adr_0, read_adr_1;
  logic              flag_in_0, flag_in_1;
  logic [SIZE-1:0]   write_adr;
  logic              write_en;
  logic              write_is_valid;
  logic [SIZE:0]     occupancy;
  logic [CNT_W-1:0]  fail_count;

  flag_access_controller #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_adr_0(req_adr_0), .req_adr_1(req_adr_1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ok(resp_ok),
    .resp_slot(resp_slot), .resp_which(resp_which),
    .read_adr_0(read_adr_0), .read_adr_1(read_adr_1),
    .flag_in_0(flag_in_0), .flag_in_1(flag_in_1),
    .write_adr(write_adr), .write_en(write_en), .write_is_valid(write_is_valid),
    .occupancy(occupancy), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // Flag store: registered reads, write on strobe, cleared by reset
  logic store [NSLOT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) store[i] <= 1'b0;
      flag_in_0 <= 1'b0;
      flag_in_1 <= 1'b0;
    end else begin
      flag_in_0 <= store[read_adr_0];
      flag_in_1 <= store[read_adr_1];
      if (write_en) store[write_adr] <= write_is_valid;
    end
  end

  // Model state
  bit model_set [NSLOT];
  int model_occ  = 0;
  int model_fail = 0;

  // Expectations seen by the compare process
  bit              chk_en = 1'b0;
  bit              exp_ready = 1'b1;
  bit              exp_resp_valid = 1'b0;
  bit              exp_we = 1'b0;
  bit              exp_rd = 1'b0;
  bit              exp_ok = 1'b0;
  logic [SIZE-1:0] exp_slot = '0;
  bit              exp_which = 1'b0;
  logic [SIZE-1:0] exp_wadr = '0;
  bit              exp_wval = 1'b0;
  logic [SIZE-1:0] exp_ra0 = '0, exp_ra1 = '0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the expectations
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready",  {31'd0, req_ready},  {31'd0, exp_ready});
      check("resp_valid", {31'd0, resp_valid}, {31'd0, exp_resp_valid});
      check("write_en",   {31'd0, write_en},   {31'd0, exp_we});
      check("occupancy",  {21'd0, occupancy},  model_occ);
      check("fail_count", {16'd0, fail_count}, model_fail);
      if (exp_resp_valid) begin
        check("resp_ok",    {31'd0, resp_ok},    {31'd0, exp_ok});
        check("resp_slot",  {22'd0, resp_slot},  {22'd0, exp_slot});
        check("resp_which", {31'd0, resp_which}, {31'd0, exp_which});
      end
      if (exp_we) begin
        check("write_adr",      {22'd0, write_adr},      {22'd0, exp_wadr});
        check("write_is_valid", {31'd0, write_is_valid}, {31'd0, exp_wval});
      end
      if (exp_rd) begin
        check("read_adr_0", {22'd0, read_adr_0}, {22'd0, exp_ra0});
        check("read_adr_1", {22'd0, read_adr_1}, {22'd0, exp_ra1});
      end
    end
  end

  // Transaction-level model: decide the outcome from slot occupancy
  task automatic model_apply(input logic [1:0] op, input logic [SIZE-1:0] a0, input logic [SIZE-1:0] a1);
    exp_ok = 1'b0; exp_slot = a0; exp_which = 1'b0; exp_we = 1'b0; exp_wadr = a0; exp_wval = 1'b0;
    if (op == 2'd0) begin
      if (model_set[a0])      begin exp_ok = 1'b1; end
      else if (model_set[a1]) begin exp_ok = 1'b1; exp_slot = a1; exp_which = 1'b1; end
      else                    begin exp_slot = a1; exp_which = 1'b1; end
    end else if (op == 2'd1) begin
      if (!model_set[a0]) begin
        exp_ok = 1'b1; exp_we = 1'b1; exp_wval = 1'b1; model_set[a0] = 1'b1; model_occ++;
      end else if (!model_set[a1]) begin
        exp_ok = 1'b1; exp_slot = a1; exp_which = 1'b1; exp_we = 1'b1; exp_wadr = a1; exp_wval = 1'b1;
        model_set[a1] = 1'b1; model_occ++;
      end else begin
        model_fail++;
      end
    end else if (op == 2'd2) begin
      exp_ok = model_set[a0]; exp_we = 1'b1;
      if (model_set[a0]) model_occ--;
      model_set[a0] = 1'b0;
    end
  endtask

  // One full transaction; hold = extra cycles resp_ready stays low
  task automatic do_req(input string tag, input logic [1:0] op, input logic [SIZE-1:0] a0,
                        input logic [SIZE-1:0] a1, input int hold,
                        input bit e_ok, input logic [SIZE-1:0] e_slot, input bit e_which);
    req_valid = 1'b1; req_op = op; req_adr_0 = a0; req_adr_1 = a1;
    @(posedge clk); #2;                    // READ
    req_valid = 1'b0; exp_ready = 1'b0; exp_rd = 1'b1; exp_ra0 = a0; exp_ra1 = a1;
    @(posedge clk); #2;                    // WAIT
    @(posedge clk); #2;                    // first RESP cycle
    exp_rd = 1'b0;
    model_apply(op, a0, a1);
    exp_resp_valid = 1'b1;
    check({tag, "_model_ok"},    {31'd0, exp_ok},    {31'd0, e_ok});
    check({tag, "_model_slot"},  {22'd0, exp_slot},  {22'd0, e_slot});
    check({tag, "_model_which"}, {31'd0, exp_which}, {31'd0, e_which});
    resp_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      exp_we = 1'b0;
      if (i == hold - 1) resp_ready = 1'b1;
    end
    @(posedge clk); #2;                    // back in IDLE
    resp_ready = 1'b0; exp_we = 1'b0; exp_resp_valid = 1'b0; exp_ready = 1'b1;
  endtask

  // Insert aborted by reset while in WAIT
  task automatic do_abort(input logic [SIZE-1:0] a0, input logic [SIZE-1:0] a1);
    req_valid = 1'b1; req_op = 2'b01; req_adr_0 = a0; req_adr_1 = a1;
    @(posedge clk); #2;
    req_valid = 1'b0; exp_ready = 1'b0;
    @(posedge clk); #2;                    // WAIT
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < NSLOT; i++) model_set[i] = 1'b0;
    model_occ = 0; model_fail = 0;
    exp_ready = 1'b1; exp_resp_valid = 1'b0; exp_we = 1'b0;
    @(posedge clk); #2;
    check("abort_occ_lit",   {21'd0, occupancy},  32'd0);
    check("abort_rvalid_lit", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NSLOT; i++) model_set[i] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;                         // reset still high: reset values checked
    @(posedge clk); #2;
    reset = 1'b0;
    check("rst_ready_lit", {31'd0, req_ready}, 32'd1);
    check("rst_slot_lit",  {22'd0, resp_slot}, 32'd0);
    check("rst_wadr_lit",  {22'd0, write_adr}, 32'd0);

    do_req("ins1", 2'b01, 10'd5, 10'd9, 0, 1'b1, 10'd5, 1'b0);
    check("ins1_occ_lit", {21'd0, occupancy}, 32'd1);
    do_req("ins2", 2'b01, 10'd5, 10'd9, 0, 1'b1, 10'd9, 1'b1);
    check("ins2_occ_lit", {21'd0, occupancy}, 32'd2);
    do_req("ins3", 2'b01, 10'd5, 10'd9, 0, 1'b0, 10'd5, 1'b0);
    check("ins3_fail_lit", {16'd0, fail_count}, 32'd1);
    do_req("lk1", 2'b00, 10'd7, 10'd9, 0, 1'b1, 10'd9, 1'b1);
    do_req("lk2", 2'b00, 10'd7, 10'd8, 0, 1'b0, 10'd8, 1'b1);
    do_req("lk3", 2'b00, 10'd5, 10'd7, 1, 1'b1, 10'd5, 1'b0);
    do_req("del1", 2'b10, 10'd5, 10'd3, 0, 1'b1, 10'd5, 1'b0);
    check("del1_occ_lit", {21'd0, occupancy}, 32'd1);
    do_req("del2", 2'b10, 10'd5, 10'd3, 0, 1'b0, 10'd5, 1'b0);
    check("del2_occ_lit", {21'd0, occupancy}, 32'd1);
    do_req("same1", 2'b01, 10'd12, 10'd12, 5, 1'b1, 10'd12, 1'b0);
    do_req("same2", 2'b01, 10'd12, 10'd12, 0, 1'b0, 10'd12, 1'b0);
    check("same2_fail_lit", {16'd0, fail_count}, 32'd2);
    do_req("rsvd", 2'b11, 10'd20, 10'd21, 2, 1'b0, 10'd20, 1'b0);
    check("rsvd_occ_lit", {21'd0, occupancy}, 32'd2);
    do_req("hi", 2'b01, 10'd1023, 10'd0, 0, 1'b1, 10'd1023, 1'b0);

    do_abort(10'd30, 10'd31);
    do_req("post_lk1", 2'b00, 10'd30, 10'd31, 0, 1'b0, 10'd31, 1'b1);
    do_req("post_lk2", 2'b00, 10'd9, 10'd12, 0, 1'b0, 10'd12, 1'b1);
    do_req("post_ins", 2'b01, 10'd9, 10'd4, 0, 1'b1, 10'd9, 1'b0);
    check("post_occ_lit", {21'd0, occupancy}, 32'd1);

    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
